// File: rtl/fp_register_write_stage_pkg.sv
// Shared types and widths for the FP register-write stage.
// Lane bundle, flag and active-list pointer types live here.
package fp_register_write_stage_pkg;

  localparam int FP_ISSUE_WIDTH = 2;
  localparam int FP_DATA_WIDTH  = 32;
  localparam int PREG_WIDTH     = 6;
  localparam int AL_PTR_WIDTH   = 7;
  localparam int FFLAGS_WIDTH   = 5;

  typedef logic [FFLAGS_WIDTH-1:0] fflags_t;
  typedef logic [AL_PTR_WIDTH-1:0] al_ptr_t;

  typedef struct packed {
    logic                     valid;
    logic [PREG_WIDTH-1:0]    preg;
    logic [FP_DATA_WIDTH-1:0] data;
    al_ptr_t                  al_ptr;
    fflags_t                  fflags;
  } fp_rw_reg_t;

  // Age of an entry relative to the head; wrap falls out of the modulus.
  function automatic al_ptr_t al_dist(al_ptr_t p, al_ptr_t head);
    return p - head;
  endfunction

endpackage

// File: rtl/age_comparator.sv
// Flags an active-list entry as killed when a flush covers it.
// Younger-or-equal than flush_ptr, measured from al_head.
module age_comparator
  import fp_register_write_stage_pkg::*;
(
  input  al_ptr_t p,
  input  al_ptr_t flush_ptr,
  input  al_ptr_t al_head,
  input  logic    flush,
  output logic    killed
);

  al_ptr_t p_dist;
  al_ptr_t f_dist;

  assign p_dist = al_dist(p, al_head);
  assign f_dist = al_dist(flush_ptr, al_head);
  assign killed = flush & (p_dist >= f_dist);

endmodule

// File: rtl/fp_register_write_stage.sv
// FP register-write stage: latches FP results, writes the FP PRF,
// reports completion and accumulates sticky fflags.
module fp_register_write_stage
  import fp_register_write_stage_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [FP_ISSUE_WIDTH-1:0]              in_valid,
  input  logic [FP_ISSUE_WIDTH*PREG_WIDTH-1:0]    in_preg,
  input  logic [FP_ISSUE_WIDTH*FP_DATA_WIDTH-1:0] in_data,
  input  logic [FP_ISSUE_WIDTH*AL_PTR_WIDTH-1:0]  in_al_ptr,
  input  logic [FP_ISSUE_WIDTH*FFLAGS_WIDTH-1:0]  in_fflags,
  input  logic                                   stall,
  input  logic                                   flush,
  input  logic [AL_PTR_WIDTH-1:0]                flush_ptr,
  input  logic [AL_PTR_WIDTH-1:0]                al_head,
  input  logic                                   csr_fflags_clear,
  output logic [FP_ISSUE_WIDTH-1:0]              rf_we,
  output logic [FP_ISSUE_WIDTH*PREG_WIDTH-1:0]    rf_waddr,
  output logic [FP_ISSUE_WIDTH*FP_DATA_WIDTH-1:0] rf_wdata,
  output logic [FP_ISSUE_WIDTH-1:0]              cmp_valid,
  output logic [FP_ISSUE_WIDTH*AL_PTR_WIDTH-1:0]  cmp_al_ptr,
  output logic [FFLAGS_WIDTH-1:0]                fflags_sticky
);

  localparam int N  = FP_ISSUE_WIDTH;
  localparam int PW = PREG_WIDTH;
  localparam int DW = FP_DATA_WIDTH;
  localparam int AW = AL_PTR_WIDTH;
  localparam int FW = FFLAGS_WIDTH;

  fp_rw_reg_t    stage_q [N];
  fp_rw_reg_t    stage_d [N];
  logic [N-1:0]  in_kill;
  logic [N-1:0]  st_kill;
  logic [N-1:0]  fire;
  fflags_t       fflags_q;
  fflags_t       fflags_d;
  fflags_t       cmp_flags;

  for (genvar i = 0; i < N; i++) begin : g_lane
    age_comparator u_in_kill (
      .p         (in_al_ptr[i*AW +: AW]),
      .flush_ptr (flush_ptr),
      .al_head   (al_head),
      .flush     (flush),
      .killed    (in_kill[i])
    );

    age_comparator u_st_kill (
      .p         (stage_q[i].al_ptr),
      .flush_ptr (flush_ptr),
      .al_head   (al_head),
      .flush     (flush),
      .killed    (st_kill[i])
    );

    assign fire[i] = stage_q[i].valid & ~stall & ~st_kill[i];

    assign rf_we[i]                 = fire[i];
    assign cmp_valid[i]             = fire[i];
    assign rf_waddr[i*PW +: PW]     = stage_q[i].preg;
    assign rf_wdata[i*DW +: DW]     = stage_q[i].data;
    assign cmp_al_ptr[i*AW +: AW]   = stage_q[i].al_ptr;
  end

  always_comb begin
    cmp_flags = '0;
    for (int i = 0; i < N; i++) begin
      stage_d[i] = stage_q[i];
      if (stall) begin
        stage_d[i].valid = stage_q[i].valid & ~st_kill[i];
      end else begin
        stage_d[i].valid  = in_valid[i] & ~in_kill[i];
        stage_d[i].preg   = in_preg[i*PW +: PW];
        stage_d[i].data   = in_data[i*DW +: DW];
        stage_d[i].al_ptr = in_al_ptr[i*AW +: AW];
        stage_d[i].fflags = in_fflags[i*FW +: FW];
      end
      if (fire[i]) cmp_flags = cmp_flags | stage_q[i].fflags;
    end
    // Completions in the clear cycle are ORed after the clear.
    fflags_d = (csr_fflags_clear ? '0 : fflags_q) | cmp_flags;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) stage_q[i] <= '0;
      fflags_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) stage_q[i] <= stage_d[i];
      fflags_q <= fflags_d;
    end
  end

  assign fflags_sticky = fflags_q;

  for (genvar i = 0; i < N; i++) begin : g_chk_i
    for (genvar j = i + 1; j < N; j++) begin : g_chk_j
      a_distinct_preg: assert property (
        @(posedge clk) disable iff (!rst)
        !(in_valid[i] && in_valid[j] &&
          in_preg[i*PW +: PW] == in_preg[j*PW +: PW]))
        else $error("duplicate in_preg on lanes %0d/%0d", i, j);
    end
  end

endmodule

// File: tb/tb_fp_register_write_stage.sv
// Scoreboard bench: a reference model queues expected writes/flags,
// an independent monitor pops and compares every cycle.
module tb_fp_register_write_stage;
  import fp_register_write_stage_pkg::*;

  localparam int N = FP_ISSUE_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         in_valid;
  logic [N*6-1:0]       in_preg;
  logic [N*32-1:0]      in_data;
  logic [N*7-1:0]       in_al_ptr;
  logic [N*5-1:0]       in_fflags;
  logic                 stall, flush, csr_fflags_clear;
  logic [6:0]           flush_ptr, al_head;
  logic [N-1:0]         rf_we, cmp_valid;
  logic [N*6-1:0]       rf_waddr;
  logic [N*32-1:0]      rf_wdata;
  logic [N*7-1:0]       cmp_al_ptr;
  logic [4:0]           fflags_sticky;

  fp_register_write_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_preg(in_preg), .in_data(in_data),
    .in_al_ptr(in_al_ptr), .in_fflags(in_fflags),
    .stall(stall), .flush(flush), .flush_ptr(flush_ptr),
    .al_head(al_head), .csr_fflags_clear(csr_fflags_clear),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .cmp_valid(cmp_valid), .cmp_al_ptr(cmp_al_ptr),
    .fflags_sticky(fflags_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         lane;
    logic [5:0] preg;
    logic [31:0] data;
    logic [6:0] ptr;
  } wr_t;

  typedef struct {
    int         cyc;
    logic [4:0] v;
  } st_t;

  wr_t wq[$];
  st_t sq[$];
  int  tcyc   = 0;
  int  n_chk  = 0;
  int  n_pass = 0;
  bit  done   = 0;

  logic       s_valid [N];
  logic [5:0] s_preg  [N];
  logic [31:0] s_data [N];
  logic [6:0] s_ptr   [N];
  logic [4:0] s_ff    [N];
  logic       s_stall, s_flush, s_clr, s_rst;
  logic [6:0] s_fptr, s_head;

  bit         m_v    [N];
  logic [5:0] m_preg [N];
  logic [31:0] m_data [N];
  logic [6:0] m_ptr  [N];
  logic [4:0] m_ff   [N];
  logic [4:0] m_sticky = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h want %0h", nm, tcyc, act, exp);
  endtask

  function automatic bit killed(input logic [6:0] p);
    int dp, df;
    dp = (int'(p) - int'(s_head) + 128) % 128;
    df = (int'(s_fptr) - int'(s_head) + 128) % 128;
    return s_flush && (dp >= df);
  endfunction

  task automatic idle();
    for (int i = 0; i < N; i++) begin
      s_valid[i] = 0; s_preg[i] = 6'(i); s_data[i] = '0;
      s_ptr[i] = '0; s_ff[i] = '0;
    end
    s_stall = 0; s_flush = 0; s_clr = 0; s_fptr = '0;
  endtask

  // One cycle: apply shadow inputs at negedge, advance the model.
  task automatic step();
    wr_t        w;
    st_t        s;
    logic [4:0] acc;
    @(negedge clk);
    tcyc++;
    rst = s_rst; stall = s_stall; flush = s_flush;
    flush_ptr = s_fptr; al_head = s_head; csr_fflags_clear = s_clr;
    for (int i = 0; i < N; i++) begin
      in_valid[i]         = s_valid[i];
      in_preg[i*6 +: 6]   = s_preg[i];
      in_data[i*32 +: 32] = s_data[i];
      in_al_ptr[i*7 +: 7] = s_ptr[i];
      in_fflags[i*5 +: 5] = s_ff[i];
    end
    s.cyc = tcyc;
    s.v   = s_rst ? m_sticky : 5'd0;
    sq.push_back(s);
    if (!s_rst) begin
      for (int i = 0; i < N; i++) m_v[i] = 0;
      m_sticky = '0;
      return;
    end
    acc = '0;
    for (int i = 0; i < N; i++) begin
      if (m_v[i] && !s_stall && !killed(m_ptr[i])) begin
        w.cyc = tcyc; w.lane = i; w.preg = m_preg[i];
        w.data = m_data[i]; w.ptr = m_ptr[i];
        wq.push_back(w);
        acc |= m_ff[i];
      end
    end
    m_sticky = (s_clr ? 5'd0 : m_sticky) | acc;
    for (int i = 0; i < N; i++) begin
      if (s_stall) begin
        m_v[i] = m_v[i] && !killed(m_ptr[i]);
      end else begin
        m_v[i]    = s_valid[i] && !killed(s_ptr[i]);
        m_preg[i] = s_preg[i]; m_data[i] = s_data[i];
        m_ptr[i]  = s_ptr[i];  m_ff[i]   = s_ff[i];
      end
    end
  endtask

  initial begin : monitor
    st_t s;
    wr_t w;
    bit  fire, exp;
    int  c;
    while (!done) begin
      @(negedge clk);
      #4;
      if (!done) begin
        c = tcyc;
        while (sq.size() > 0 && sq[0].cyc < c) void'(sq.pop_front());
        if (sq.size() > 0 && sq[0].cyc == c) begin
          s = sq.pop_front();
          chk("fflags_sticky", fflags_sticky, s.v);
        end
        while (wq.size() > 0 && wq[0].cyc < c) begin
          w = wq.pop_front();
          chk("stale_expected_write", 0, 1);
        end
        for (int i = 0; i < N; i++) begin
          fire = rf_we[i] | cmp_valid[i];
          exp  = wq.size() > 0 && wq[0].cyc == c && wq[0].lane == i;
          chk($sformatf("write_lane%0d", i), fire, exp);
          if (exp) begin
            w = wq.pop_front();
            if (fire) begin
              chk("we_cmp_pair", {rf_we[i], cmp_valid[i]}, 2'b11);
              chk("rf_waddr", rf_waddr[i*6 +: 6], w.preg);
              chk("rf_wdata", rf_wdata[i*32 +: 32], w.data);
              chk("cmp_al_ptr", cmp_al_ptr[i*7 +: 7], w.ptr);
            end
          end
        end
      end
    end
  end

  initial begin : stim
    rst = 0; in_valid = '0; in_preg = '0; in_data = '0;
    in_al_ptr = '0; in_fflags = '0; stall = 0; flush = 0;
    flush_ptr = '0; al_head = '0; csr_fflags_clear = 0;
    idle();
    s_rst = 0; s_head = '0;
    #2;
    chk("reset_rf_we", rf_we, 0);
    chk("reset_cmp_valid", cmp_valid, 0);
    chk("reset_fflags", fflags_sticky, 0);
    step(); step();
    s_rst = 1;
    step();

    // Latency: one write the cycle after capture, none after.
    s_valid[0] = 1; s_preg[0] = 6'd5; s_data[0] = 32'h3F80_0000;
    s_ptr[0] = 7'h01;
    step();
    idle();
    step(); #1;
    chk("t1_rf_we", rf_we, 2'b01);
    chk("t1_waddr", rf_waddr[5:0], 6'd5);
    chk("t1_wdata", rf_wdata[31:0], 32'h3F80_0000);
    chk("t1_cmp_valid", cmp_valid, 2'b01);
    step(); #1;
    chk("t1_quiet", rf_we, 2'b00);

    // Stall hold then a single release write.
    s_valid[1] = 1; s_preg[1] = 6'd9; s_data[1] = 32'hDEAD_BEEF;
    s_ptr[1] = 7'h02;
    step();
    idle(); s_stall = 1;
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      chk("t2_stalled", rf_we, 2'b00);
    end
    s_stall = 0;
    step(); #1;
    chk("t2_release", rf_we, 2'b10);
    step(); #1;
    chk("t2_no_dup", rf_we, 2'b00);

    // Flush across the pointer wrap.
    s_head = 7'h7C;
    s_valid[0] = 1; s_preg[0] = 6'd1; s_ptr[0] = 7'h7E; s_data[0] = 32'h1;
    s_valid[1] = 1; s_preg[1] = 6'd2; s_ptr[1] = 7'h03; s_data[1] = 32'h2;
    step();
    idle(); s_flush = 1; s_fptr = 7'h02;
    step(); #1;
    chk("t3_flush_wrap", cmp_valid, 2'b01);
    idle();
    step();

    // fflags accumulation and clear.
    s_valid[0] = 1; s_preg[0] = 6'd3; s_ff[0] = 5'b00001; s_ptr[0] = 7'h7D;
    s_valid[1] = 1; s_preg[1] = 6'd4; s_ff[1] = 5'b00100; s_ptr[1] = 7'h7E;
    step();
    idle();
    s_valid[0] = 1; s_preg[0] = 6'd6; s_ff[0] = 5'b01000; s_ptr[0] = 7'h7F;
    step();
    idle(); s_clr = 1;
    step(); #1;
    chk("t4_accum", fflags_sticky, 5'b00101);
    idle();
    step(); #1;
    chk("t4_clear_survive", fflags_sticky, 5'b01000);

    // Reset while an entry is held under stall.
    s_valid[0] = 1; s_preg[0] = 6'd7; s_ptr[0] = 7'h00; s_ff[0] = 5'b10000;
    step();
    idle(); s_stall = 1;
    step();
    idle(); s_rst = 0;
    step(); #1;
    chk("t5_reset_we", rf_we, 2'b00);
    chk("t5_reset_cmp", cmp_valid, 2'b00);
    s_rst = 1;
    step(); #1;
    chk("t5_no_stale", rf_we, 2'b00);
    chk("t5_fflags_zero", fflags_sticky, 5'd0);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      s_head = s_head + 7'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
        s_valid[i] = 1'($urandom_range(0, 1));
        s_data[i]  = $urandom;
        s_ptr[i]   = s_head + 7'($urandom_range(0, 63));
        s_ff[i]    = 5'($urandom);
      end
      s_preg[0] = 6'($urandom);
      s_preg[1] = s_preg[0] ^ 6'($urandom_range(1, 63));
      s_stall = ($urandom_range(0, 3) == 0);
      s_flush = ($urandom_range(0, 5) == 0);
      s_fptr  = s_head + 7'($urandom_range(0, 63));
      s_clr   = ($urandom_range(0, 9) == 0);
      step();
    end

    idle();
    for (int k = 0; k < 4; k++) step();
    #5;
    done = 1;
    #10;
    chk("drain_queue", wq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
